// File: rtl/portal_pipe_dispatch_if.sv
// rtl/portal_pipe_dispatch_if.sv - pipe input and method channel bundle for portal_pipe_dispatch
interface portal_pipe_dispatch_if #(
    parameter int NUM_METHODS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 32
);
    logic                              pipe_enq_ena;
    logic [DATA_WIDTH+TAG_WIDTH-1:0]   pipe_enq_v;
    logic                              pipe_enq_rdy;
    logic [NUM_METHODS-1:0]            method_ena;
    logic [NUM_METHODS*DATA_WIDTH-1:0] method_v;
    logic [NUM_METHODS-1:0]            method_rdy;

    modport master (
        output pipe_enq_ena, pipe_enq_v, method_rdy,
        input  pipe_enq_rdy, method_ena, method_v
    );

    modport slave (
        input  pipe_enq_ena, pipe_enq_v, method_rdy,
        output pipe_enq_rdy, method_ena, method_v
    );
endinterface

// File: rtl/portal_pipe_dispatch.sv
// rtl/portal_pipe_dispatch.sv - tag-decoded pipe word dispatcher with per-method FIFOs
module portal_pipe_dispatch #(
    parameter int NUM_METHODS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 32,
    parameter int TAG_BASE    = 1,
    parameter int FIFO_DEPTH  = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                             CLK,
    input  logic                                             RST,
    portal_pipe_dispatch_if.slave                            bus,
    output logic [CNT_WIDTH-1:0]                             o_drop_count,
    output logic [TAG_WIDTH-1:0]                             o_last_bad_tag,
    output logic [NUM_METHODS*($clog2(FIFO_DEPTH)+1)-1:0]    o_occupancy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TAG_WIDTH-1:0] LP_BASE  = TAG_WIDTH'(TAG_BASE);
    localparam logic [TAG_WIDTH-1:0] LP_NUM   = TAG_WIDTH'(NUM_METHODS);
    localparam logic [CW-1:0]        LP_DEPTH = CW'(FIFO_DEPTH);

    logic [TAG_WIDTH-1:0]   w_tag;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [TAG_WIDTH-1:0]   w_off;
    logic                   w_tag_ok;
    logic                   w_drop;
    logic [NUM_METHODS-1:0] w_hit;
    logic [NUM_METHODS-1:0] w_full;
    logic [NUM_METHODS-1:0] w_push;
    logic [NUM_METHODS-1:0] w_pop;

    logic [CNT_WIDTH-1:0]   r_drop_count;
    logic [TAG_WIDTH-1:0]   r_last_bad_tag;

    assign w_tag  = bus.pipe_enq_v[TAG_WIDTH-1:0];
    assign w_data = bus.pipe_enq_v[TAG_WIDTH +: DATA_WIDTH];
    assign w_off  = w_tag - LP_BASE;

    // The explicit lower bound stops tags below the base from aliasing into range.
    assign w_tag_ok = (w_tag >= LP_BASE) && (w_off < LP_NUM);
    assign w_drop   = bus.pipe_enq_ena && !w_tag_ok;

    assign bus.pipe_enq_rdy = !w_tag_ok || ~|(w_hit & w_full);

    generate
        for (genvar c = 0; c < NUM_METHODS; c++) begin : gen_ch
            logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
            logic [PW-1:0]         r_wptr;
            logic [PW-1:0]         r_rptr;
            logic [CW-1:0]         r_count;

            assign w_hit[c]  = w_tag_ok && (w_off == TAG_WIDTH'(c));
            assign w_full[c] = (r_count == LP_DEPTH);
            assign w_push[c] = bus.pipe_enq_ena && w_hit[c] && !w_full[c];
            assign w_pop[c]  = (r_count != '0) && bus.method_rdy[c];

            assign bus.method_ena[c]                          = (r_count != '0);
            assign bus.method_v[c*DATA_WIDTH +: DATA_WIDTH]   = r_mem[r_rptr];
            assign o_occupancy[c*CW +: CW]                    = r_count;

            // Storage is cleared on reset so an idle channel never presents X.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < FIFO_DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[c]) begin
                        r_mem[r_wptr] <= w_data;
                        r_wptr        <= r_wptr + 1'b1;
                    end
                    if (w_pop[c]) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    case ({w_push[c], w_pop[c]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_drop_count   <= '0;
            r_last_bad_tag <= '0;
        end else if (w_drop) begin
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
            r_last_bad_tag <= w_tag;
        end
    end

    assign o_drop_count   = r_drop_count;
    assign o_last_bad_tag = r_last_bad_tag;
endmodule
